id_decode_pipe: RTL and testbench

ID_DECODE_PIPE -- requirements
Module: id_decode_pipe

---
 rtl/id_decode_pkg.sv | 62 ++++++
 rtl/id_decode_core.sv | 191 +++++++++++++++++++
 rtl/id_decode_pipe.sv | 97 +++++++++
 tb/tb_id_decode_pipe.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_decode_pkg.sv
// Shared decode definitions: opcodes, ALU codes, access sizes, control bundle
// and the immediate sign-extension helper.
package id_decode_pkg;

  localparam logic [6:0] OPC_BUBBLE = 7'b0000000;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_SLL   = 5'd2;
  localparam logic [4:0] ALU_SLT   = 5'd3;
  localparam logic [4:0] ALU_SLTU  = 5'd4;
  localparam logic [4:0] ALU_XOR   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_OR    = 5'd8;
  localparam logic [4:0] ALU_AND   = 5'd9;
  localparam logic [4:0] ALU_PASSB = 5'd10;
  localparam logic [4:0] ALU_BEQ   = 5'd11;
  localparam logic [4:0] ALU_BNE   = 5'd12;
  localparam logic [4:0] ALU_BLT   = 5'd13;
  localparam logic [4:0] ALU_BGE   = 5'd14;
  localparam logic [4:0] ALU_MUL   = 5'd16;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MEM = 2'd1;
  localparam logic [1:0] M2R_PC4 = 2'd2;

  localparam logic [1:0] JUMP_NONE   = 2'd0;
  localparam logic [1:0] JUMP_BRANCH = 2'd1;
  localparam logic [1:0] JUMP_JAL    = 2'd2;
  localparam logic [1:0] JUMP_JALR   = 2'd3;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [1:0] mem_to_reg;
    logic [1:0] jump;
    logic       is_signed;
    logic [1:0] inst_size;
  } ctl_t;

  function automatic logic [63:0] id_sign_extend(input logic [31:0] value);
    return {{32{value[31]}}, value};
  endfunction

endpackage

// File: rtl/id_decode_core.sv
// Combinational instruction decoder: control bundle, ALU code, immediate,
// register fields and which source registers the instruction actually reads.
module id_decode_core
  import id_decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b1
) (
  input  logic [31:0]     inst,
  output ctl_t            ctl,
  output logic [4:0]      alu_op,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            illegal,
  output logic            uses_rs1,
  output logic            uses_rs2
);

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm32;
  logic        shift_zero;
  logic        shift_arith;
  logic [31:0] shamt;

  assign f3  = inst[14:12];
  assign f7  = inst[31:25];
  assign rs1 = inst[19:15];
  assign rs2 = inst[24:20];
  assign rd  = inst[11:7];

  // RV64 shifts carry a 6-bit shamt, leaving a 6-bit funct field above it
  assign shift_zero  = (XLEN == 64) ? (inst[31:26] == 6'b000000) : (f7 == 7'b0000000);
  assign shift_arith = (XLEN == 64) ? (inst[31:26] == 6'b010000) : (f7 == 7'b0100000);
  assign shamt       = (XLEN == 64) ? {26'd0, inst[25:20]} : {27'd0, inst[24:20]};

  assign imm = XLEN'(id_sign_extend(imm32));

  // Field decode; an illegal encoding collapses to a side-effect-free bundle
  always_comb begin
    ctl           = '0;
    ctl.is_signed = 1'b1;
    alu_op        = ALU_ADD;
    imm32         = 32'd0;
    illegal       = 1'b0;
    uses_rs1      = 1'b0;
    uses_rs2      = 1'b0;
    case (inst[6:0])
      OPC_BUBBLE: ctl.is_signed = 1'b0;
      OPC_LUI: begin
        ctl.reg_write = 1'b1;
        ctl.alu_src_b = 1'b1;
        alu_op        = ALU_PASSB;
        imm32         = {inst[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        ctl.reg_write = 1'b1;
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 1'b1;
        imm32         = {inst[31:12], 12'd0};
      end
      OPC_JAL: begin
        ctl.reg_write  = 1'b1;
        ctl.alu_src_a  = 1'b1;
        ctl.mem_to_reg = M2R_PC4;
        ctl.jump       = JUMP_JAL;
        imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OPC_JALR: begin
        ctl.reg_write  = 1'b1;
        ctl.alu_src_a  = 1'b1;
        ctl.mem_to_reg = M2R_PC4;
        ctl.jump       = JUMP_JALR;
        imm32          = {{20{inst[31]}}, inst[31:20]};
        uses_rs1       = 1'b1;
        if (f3 != 3'd0) illegal = 1'b1; else illegal = 1'b0;
      end
      OPC_BRANCH: begin
        ctl.jump = JUMP_BRANCH;
        imm32    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        case (f3)
          3'b000: alu_op = ALU_BEQ;
          3'b001: alu_op = ALU_BNE;
          3'b100: alu_op = ALU_BLT;
          3'b101: alu_op = ALU_BGE;
          3'b110: begin alu_op = ALU_BLT; ctl.is_signed = 1'b0; end
          3'b111: begin alu_op = ALU_BGE; ctl.is_signed = 1'b0; end
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        ctl.mem_read   = 1'b1;
        ctl.reg_write  = 1'b1;
        ctl.alu_src_b  = 1'b1;
        ctl.mem_to_reg = M2R_MEM;
        ctl.inst_size  = f3[1:0];
        imm32          = {{20{inst[31]}}, inst[31:20]};
        uses_rs1       = 1'b1;
        case (f3)
          3'b000, 3'b001, 3'b010: ctl.is_signed = 1'b1;
          3'b100, 3'b101:         ctl.is_signed = 1'b0;
          default:                illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        ctl.mem_write = 1'b1;
        ctl.alu_src_b = 1'b1;
        ctl.inst_size = f3[1:0];
        imm32         = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        if (f3 > 3'd2) illegal = 1'b1; else illegal = 1'b0;
      end
      OPC_OP_IMM: begin
        ctl.reg_write = 1'b1;
        ctl.alu_src_b = 1'b1;
        imm32         = {{20{inst[31]}}, inst[31:20]};
        uses_rs1      = 1'b1;
        case (f3)
          3'b000: alu_op = ALU_ADD;
          3'b010: alu_op = ALU_SLT;
          3'b011: begin alu_op = ALU_SLTU; ctl.is_signed = 1'b0; end
          3'b100: alu_op = ALU_XOR;
          3'b110: alu_op = ALU_OR;
          3'b111: alu_op = ALU_AND;
          3'b001: begin
            alu_op = ALU_SLL;
            imm32  = shamt;
            if (!shift_zero) illegal = 1'b1; else illegal = 1'b0;
          end
          3'b101: begin
            alu_op = shift_arith ? ALU_SRA : ALU_SRL;
            imm32  = shamt;
            if (!shift_zero && !shift_arith) illegal = 1'b1; else illegal = 1'b0;
          end
          default: illegal = 1'b1;
        endcase
      end
      OPC_OP: begin
        ctl.reg_write = 1'b1;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        case (f7)
          7'b0000000: begin
            case (f3)
              3'b000: alu_op = ALU_ADD;
              3'b001: alu_op = ALU_SLL;
              3'b010: alu_op = ALU_SLT;
              3'b011: begin alu_op = ALU_SLTU; ctl.is_signed = 1'b0; end
              3'b100: alu_op = ALU_XOR;
              3'b101: alu_op = ALU_SRL;
              3'b110: alu_op = ALU_OR;
              3'b111: alu_op = ALU_AND;
              default: illegal = 1'b1;
            endcase
          end
          7'b0100000: begin
            case (f3)
              3'b000: alu_op = ALU_SUB;
              3'b101: alu_op = ALU_SRA;
              default: illegal = 1'b1;
            endcase
          end
          7'b0000001: begin
            // M ops occupy 16..23 in funct3 order; odd codes above MULH are unsigned
            alu_op        = ALU_MUL | {2'b00, f3};
            ctl.is_signed = !(f3 == 3'b011 || f3 == 3'b101 || f3 == 3'b111);
            if (!EN_M) illegal = 1'b1; else illegal = 1'b0;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      ctl           = '0;
      ctl.is_signed = 1'b1;
      alu_op        = ALU_ADD;
      imm32         = 32'd0;
      uses_rs1      = 1'b0;
      uses_rs2      = 1'b0;
    end else begin
      ctl.inst_size = ctl.inst_size;
    end
  end

endmodule

// File: rtl/id_decode_pipe.sv
// Registered decode stage: valid/ready handshake, output register,
// load-use bubble counter and branch flush.
module id_decode_pipe
  import id_decode_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit EN_M       = 1'b1,
  parameter int LU_BUBBLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output ctl_t            ctl,
  output logic [4:0]      alu_op,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] pc_out,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            illegal
);

  ctl_t            dec_ctl;
  logic [4:0]      dec_alu_op;
  logic [XLEN-1:0] dec_imm;
  logic [4:0]      dec_rs1, dec_rs2, dec_rd;
  logic            dec_illegal, uses_rs1, uses_rs2;
  logic [1:0]      cnt;
  logic [4:0]      load_rd;
  logic            lu_stall, take, is_load;

  id_decode_core #(.XLEN(XLEN), .EN_M(EN_M)) u_core (
    .inst     (inst),
    .ctl      (dec_ctl),
    .alu_op   (dec_alu_op),
    .imm      (dec_imm),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .rd       (dec_rd),
    .illegal  (dec_illegal),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  assign lu_stall = (cnt != 2'd0) && in_valid &&
                    ((uses_rs1 && dec_rs1 == load_rd) || (uses_rs2 && dec_rs2 == load_rd));
  assign in_ready = (!out_valid || out_ready) && !lu_stall && !flush;
  assign take     = in_valid && in_ready;
  assign is_load  = dec_ctl.mem_read && (dec_rd != 5'd0);

  // Output register plus load-use tracking; flush kills the slot and pending bubbles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      cnt       <= 2'd0;
      load_rd   <= 5'd0;
      ctl       <= '0;
      alu_op    <= 5'd0;
      imm       <= '0;
      pc_out    <= '0;
      rs1       <= 5'd0;
      rs2       <= 5'd0;
      rd        <= 5'd0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      cnt       <= 2'd0;
    end else begin
      if (take) begin
        out_valid <= 1'b1;
        ctl       <= dec_ctl;
        alu_op    <= dec_alu_op;
        imm       <= dec_imm;
        pc_out    <= pc;
        rs1       <= dec_rs1;
        rs2       <= dec_rs2;
        rd        <= dec_rd;
        illegal   <= dec_illegal;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (take && is_load) begin
        cnt     <= 2'(LU_BUBBLES);
        load_rd <= dec_rd;
      end else if (out_ready && cnt != 2'd0) begin
        cnt <= cnt - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_id_decode_pipe.sv
// Directed and randomized checks of id_decode_pipe against an encoder-side
// reference: each random instruction is built from fields whose decode is known.
module tb_id_decode_pipe;
  import id_decode_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, out_ready = 1'b1, flush = 1'b0;
  logic [31:0] inst = 32'd0, pc = 32'd0;
  logic        in_ready, out_valid, illegal;
  ctl_t        ctl;
  logic [4:0]  alu_op, rs1, rs2, rd;
  logic [31:0] imm, pc_out;

  logic        in_valid1 = 1'b0, out_ready1 = 1'b1, flush1 = 1'b0;
  logic [31:0] inst1 = 32'd0;
  logic [63:0] pc1 = 64'd0;
  logic        in_ready1, out_valid1, illegal1;
  ctl_t        ctl1;
  logic [4:0]  alu_op1, rs1_1, rs2_1, rd1;
  logic [63:0] imm1, pc_out1;

  id_decode_pipe #(.XLEN(32), .EN_M(1'b1), .LU_BUBBLES(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .pc(pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .ctl(ctl),
    .alu_op(alu_op), .imm(imm), .pc_out(pc_out), .rs1(rs1), .rs2(rs2), .rd(rd),
    .illegal(illegal)
  );

  id_decode_pipe #(.XLEN(64), .EN_M(1'b0), .LU_BUBBLES(1)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1), .inst(inst1),
    .pc(pc1), .flush(flush1), .out_valid(out_valid1), .out_ready(out_ready1), .ctl(ctl1),
    .alu_op(alu_op1), .imm(imm1), .pc_out(pc_out1), .rs1(rs1_1), .rs2(rs2_1), .rd(rd1),
    .illegal(illegal1)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [4:0]  alu;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic        r1, r2, ld, chk_rd;
    logic        rw, mr, mw, sg;
    logic [1:0]  jmp;
  } exp_t;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Build a random instruction from fields and record what it must decode to
  function automatic exp_t gen();
    exp_t e;
    logic [11:0] i12;
    logic [19:0] u20;
    logic [12:0] b;
    logic [4:0]  sh;
    int          k;
    i12 = 12'($urandom_range(4095));
    u20 = 20'($urandom());
    b   = {12'($urandom_range(4095)), 1'b0};
    sh  = 5'($urandom_range(31));
    k   = $urandom_range(13);
    e.rd  = 5'($urandom_range(3));
    e.rs1 = 5'($urandom_range(3));
    e.rs2 = 5'($urandom_range(3));
    e.pc  = $urandom();
    e.alu = 5'd0; e.imm = {{20{i12[11]}}, i12};
    e.r1 = 1'b1; e.r2 = 1'b0; e.ld = 1'b0; e.chk_rd = 1'b1;
    e.rw = 1'b1; e.mr = 1'b0; e.mw = 1'b0; e.sg = 1'b1; e.jmp = 2'd0;
    case (k)
      0: e.inst = {i12, e.rs1, 3'b000, e.rd, 7'h13};
      1: begin e.inst = {i12, e.rs1, 3'b100, e.rd, 7'h13}; e.alu = 5'd5; end
      2: begin e.inst = {i12, e.rs1, 3'b011, e.rd, 7'h13}; e.alu = 5'd4; e.sg = 1'b0; end
      3: begin e.inst = {7'h20, sh, e.rs1, 3'b101, e.rd, 7'h13}; e.alu = 5'd7; e.imm = {27'd0, sh}; end
      4: begin e.inst = {7'h00, e.rs2, e.rs1, 3'b000, e.rd, 7'h33}; e.imm = 32'd0; e.r2 = 1'b1; end
      5: begin e.inst = {7'h20, e.rs2, e.rs1, 3'b000, e.rd, 7'h33}; e.alu = 5'd1; e.imm = 32'd0; e.r2 = 1'b1; end
      6: begin e.inst = {7'h00, e.rs2, e.rs1, 3'b011, e.rd, 7'h33}; e.alu = 5'd4; e.imm = 32'd0; e.r2 = 1'b1; e.sg = 1'b0; end
      7: begin e.inst = {7'h01, e.rs2, e.rs1, 3'b000, e.rd, 7'h33}; e.alu = 5'd16; e.imm = 32'd0; e.r2 = 1'b1; end
      8: begin e.inst = {i12, e.rs1, 3'b010, e.rd, 7'h03}; e.mr = 1'b1; e.ld = 1'b1; end
      9: begin e.inst = {i12, e.rs1, 3'b100, e.rd, 7'h03}; e.mr = 1'b1; e.ld = 1'b1; e.sg = 1'b0; end
      10: begin
        e.inst = {i12[11:5], e.rs2, e.rs1, 3'b010, i12[4:0], 7'h23};
        e.mw = 1'b1; e.rw = 1'b0; e.r2 = 1'b1; e.chk_rd = 1'b0;
      end
      11: begin e.inst = {u20, e.rd, 7'h37}; e.imm = {u20, 12'd0}; e.alu = 5'd10; e.r1 = 1'b0; end
      12: begin
        e.inst = {b[12], b[10:5], e.rs2, e.rs1, 3'b000, b[4:1], b[11], 7'h63};
        e.imm = {{19{b[12]}}, b}; e.alu = 5'd11; e.rw = 1'b0; e.r2 = 1'b1; e.chk_rd = 1'b0; e.jmp = 2'd1;
      end
      default: begin
        e.inst = {b[12], b[10:5], e.rs2, e.rs1, 3'b110, b[4:1], b[11], 7'h63};
        e.imm = {{19{b[12]}}, b}; e.alu = 5'd13; e.rw = 1'b0; e.r2 = 1'b1; e.chk_rd = 1'b0;
        e.jmp = 2'd1; e.sg = 1'b0;
      end
    endcase
    return e;
  endfunction

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_ADD  = 32'h002101B3;
  localparam logic [31:0] I_SUB  = 32'h40628233;
  localparam logic [31:0] I_MUL  = 32'h027302B3;

  exp_t cur, held;
  logic m_valid, m_ready, m_stall, m_take;
  int   m_cnt;
  logic [4:0] m_ld;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_imm", imm, 0);
    chk("rst_rd", rd, 0);
    chk("rst_ctl", ctl, 0);
    reset = 1'b1;
    #1 chk("ready_after_rst", in_ready, 1);

    inst = I_ADDI; pc = 32'h100; in_valid = 1'b1;
    #1 chk("addi_ready", in_ready, 1);
    tick();
    chk("addi_valid", out_valid, 1);
    chk("addi_alu", alu_op, 0);
    chk("addi_imm", imm, 5);
    chk("addi_rd", rd, 1);
    chk("addi_rw", ctl.reg_write, 1);
    chk("addi_pc", pc_out, 32'h100);

    inst = I_LW;
    tick();
    chk("lw_valid", out_valid, 1);
    chk("lw_mr", ctl.mem_read, 1);
    inst = I_ADD;
    #1 chk("lu_stall_ready", in_ready, 0);
    tick();
    chk("lu_bubble", out_valid, 0);
    chk("lu_ready_again", in_ready, 1);
    tick();
    chk("lu_add_valid", out_valid, 1);
    chk("lu_add_rd", rd, 3);

    inst = I_SUB;
    tick();
    out_ready = 1'b0; inst = I_ADDI;
    for (int i = 0; i < 4; i++) begin
      #1 chk("hold_ready", in_ready, 0);
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_alu", alu_op, 1);
      chk("hold_rd", rd, 4);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    tick();
    chk("hold_single_xfer", out_valid, 0);

    inst = I_LW; in_valid = 1'b1;
    tick();
    inst = I_ADD; out_ready = 1'b0; flush = 1'b1;
    #1 chk("flush_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    chk("flush_valid", out_valid, 0);
    #1 chk("flush_cnt_clear", in_ready, 1);
    tick();
    chk("post_flush_add", out_valid, 1);
    chk("post_flush_alu", alu_op, 0);
    out_ready = 1'b1; in_valid = 1'b0;
    tick();

    inst = I_ADDI; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_beats_take", out_valid, 0);

    inst = 32'd0;
    tick();
    chk("bubble_valid", out_valid, 1);
    chk("bubble_illegal", illegal, 0);
    chk("bubble_ctl", ctl, 0);

    inst = I_MUL; inst1 = I_MUL; in_valid1 = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mul_alu", alu_op, 16);
    chk("mul_illegal", illegal, 0);
    chk("mul_rw", ctl.reg_write, 1);
    chk("mul_noM_illegal", illegal1, 1);
    chk("mul_noM_rw", ctl1.reg_write, 0);
    inst1 = 32'hFFF00093;
    tick();
    chk("x64_imm", imm1, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("x64_illegal", illegal1, 0);
    inst1 = 32'h0000007F;
    tick();
    in_valid1 = 1'b0;
    chk("bad_opc_illegal", illegal1, 1);
    chk("bad_opc_mr", ctl1.mem_read, 0);
    chk("bad_opc_jump", ctl1.jump, 0);

    inst = I_LW; in_valid = 1'b1;
    tick();
    inst = I_ADD; out_ready = 1'b0;
    #1 chk("rst_stall_ready", in_ready, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_imm", imm, 0);
    chk("async_rst_alu", alu_op, 0);
    chk("async_rst_rd", rd, 0);
    chk("async_rst_pc", pc_out, 0);
    tick();
    reset = 1'b1;
    #1 chk("rst_release_ready", in_ready, 1);
    in_valid = 1'b0; out_ready = 1'b1;

    m_valid = 1'b0; m_cnt = 0; m_ld = 5'd0;
    held = gen();
    for (int n = 0; n < 400; n++) begin
      cur       = gen();
      inst      = cur.inst;
      pc        = cur.pc;
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      flush     = ($urandom_range(15) == 0);
      m_stall = (m_cnt != 0) && in_valid &&
                ((cur.r1 && cur.rs1 == m_ld) || (cur.r2 && cur.rs2 == m_ld));
      m_ready = (!m_valid || out_ready) && !m_stall && !flush;
      m_take  = in_valid && m_ready;
      #1 chk("rnd_ready", in_ready, m_ready);
      if (flush) begin
        m_valid = 1'b0;
        m_cnt   = 0;
      end else begin
        if (m_take) begin
          m_valid = 1'b1;
          held    = cur;
        end else if (m_valid && out_ready) begin
          m_valid = 1'b0;
        end
        if (m_take && cur.ld && cur.rd != 5'd0) begin
          m_cnt = 1;
          m_ld  = cur.rd;
        end else if (out_ready && m_cnt > 0) begin
          m_cnt = m_cnt - 1;
        end
      end
      tick();
      chk("rnd_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("rnd_alu", alu_op, held.alu);
        chk("rnd_imm", imm, held.imm);
        chk("rnd_pc", pc_out, held.pc);
        chk("rnd_rw", ctl.reg_write, held.rw);
        chk("rnd_mr", ctl.mem_read, held.mr);
        chk("rnd_mw", ctl.mem_write, held.mw);
        chk("rnd_sg", ctl.is_signed, held.sg);
        chk("rnd_jump", ctl.jump, held.jmp);
        chk("rnd_illegal", illegal, 0);
        if (held.chk_rd) chk("rnd_rd", rd, held.rd);
        if (held.r1) chk("rnd_rs1", rs1, held.rs1);
        if (held.r2) chk("rnd_rs2", rs2, held.rs2);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
